ps2_host_tx: RTL



---
 rtl/ps2_host_tx_pkg.sv | 18 +
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_host_tx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: host transmitter FSM encoding and common command bytes.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pin: 2-FF synchronizer, agreement-counter deglitcher,
// and a registered strobe on each filtered 1->0 transition.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], din};
        end
    end

    // The output only flips after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= 1'b1;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync[1] == q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                q    <= sync[1];
                cnt  <= '0;
                fall <= q;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts out one command byte on device clock falls and samples the ack bit.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_CYCLES   = 50,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int PW = $clog2(PHASE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] INH_LAST   = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] START_LAST = PW'(START_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t state, state_next;
    logic [7:0]    shreg, shreg_next;
    logic          par, par_next;
    logic [3:0]    bitcnt, bitcnt_next;
    logic [PW-1:0] phase, phase_next;
    logic [TW-1:0] tocnt, tocnt_next;
    logic          data_oe_q, data_oe_next;
    logic          ack_next, done_next, error_next;

    logic clk_f, clk_fall, data_f, data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (ps2_clk_in),
        .q    (clk_f),
        .fall (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (ps2_data_in),
        .q    (data_f),
        .fall (data_fall_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            par       <= 1'b0;
            bitcnt    <= '0;
            phase     <= '0;
            tocnt     <= '0;
            data_oe_q <= 1'b0;
            ack_ok    <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            par       <= par_next;
            bitcnt    <= bitcnt_next;
            phase     <= phase_next;
            tocnt     <= tocnt_next;
            data_oe_q <= data_oe_next;
            ack_ok    <= ack_next;
            done      <= done_next;
            error     <= error_next;
        end
    end

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        par_next     = par;
        bitcnt_next  = bitcnt;
        phase_next   = phase;
        tocnt_next   = tocnt;
        data_oe_next = data_oe_q;
        ack_next     = ack_ok;
        done_next    = 1'b0;
        error_next   = 1'b0;

        case (state)
            IDLE: begin
                data_oe_next = 1'b0;
                if (tx_valid) begin
                    shreg_next  = tx_data;
                    par_next    = ~^tx_data;
                    ack_next    = 1'b0;
                    bitcnt_next = '0;
                    phase_next  = '0;
                    state_next  = INHIBIT;
                end
            end
            INHIBIT: begin
                data_oe_next = 1'b0;
                if (phase == INH_LAST) begin
                    phase_next   = '0;
                    data_oe_next = 1'b1;
                    tocnt_next   = '0;
                    state_next   = REQ;
                end else begin
                    phase_next = phase + 1'b1;
                end
            end
            REQ: begin
                data_oe_next = 1'b1;
                tocnt_next   = '0;
                if (phase == START_LAST) begin
                    state_next = SEND;
                end else begin
                    phase_next = phase + 1'b1;
                end
            end
            // Data changes while the device holds the clock low; it samples on the rise.
            SEND: begin
                tocnt_next = tocnt + 1'b1;
                if (clk_fall) begin
                    tocnt_next  = '0;
                    bitcnt_next = bitcnt + 1'b1;
                    if (bitcnt < 4'd8) begin
                        data_oe_next = ~shreg[bitcnt[2:0]];
                    end else if (bitcnt == 4'd8) begin
                        data_oe_next = ~par;
                    end else begin
                        data_oe_next = 1'b0;
                        state_next   = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                data_oe_next = 1'b0;
                tocnt_next   = tocnt + 1'b1;
                if (clk_fall) begin
                    tocnt_next = '0;
                    ack_next   = ~data_f;
                    state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                data_oe_next = 1'b0;
                tocnt_next   = tocnt + 1'b1;
                if (clk_fall) begin
                    tocnt_next = '0;
                end
                if (clk_f && data_f) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                data_oe_next = 1'b0;
                state_next   = IDLE;
            end
        endcase

        // A silent device aborts the frame from any device-clocked state.
        if ((state == SEND || state == WAIT_ACK || state == WAIT_IDLE) && tocnt == TO_LAST) begin
            state_next   = IDLE;
            data_oe_next = 1'b0;
            ack_next     = 1'b0;
            done_next    = 1'b0;
            error_next   = 1'b1;
        end
    end

    assign tx_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
    assign ps2_data_oe = data_oe_q;

endmodule
